// File: rtl/mod_memstage_pkg.sv
// Shared types for the MEM stage and its MEM/EX consumer: packets, flags,
// memory-op kinds and stage states.
package mod_memstage_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } mem_kind_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_RESP = 2'b10,
    OUT       = 2'b11
  } memstage_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_reg;

  typedef struct packed {
    logic [7:0]  ctl_opcode;
    logic [4:0]  rd;
    logic        wb_en;
    logic [63:0] operand;
  } MEM_EX;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wb_en;
    logic [63:0] result;
    flags_reg    flags;
  } EX_WB;

  // Encoding 2'b11 is illegal and behaves as a non-memory instruction.
  function automatic mem_kind_e decode_kind(input logic [1:0] kind);
    case (kind)
      2'b01:   return LOAD;
      2'b10:   return STORE;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/mod_memstage.sv
// Pipeline MEM stage: issues one 64-bit load/store at a time on the data-memory
// port and hands the MEM_EX packet plus load data to execute.
module mod_memstage
  import mod_memstage_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [63:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  MEM_EX             in_memex,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [63:0]       mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              ex_ready,
  output logic              can_execute,
  output MEM_EX             memex,
  output logic [DATA_W-1:0] load_buffer,
  output logic              loadbuffer_done,
  output logic              memstage_active,
  output logic              store_memstage_active,
  output logic              mem_err
);

  memstage_state_e   state_q, state_d;
  mem_kind_e         kind_q;
  logic [63:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        tmo_cnt;
  logic              timeout_hit;

  // Fires on the TIMEOUT-th cycle spent in WAIT_RESP.
  assign timeout_hit = (state_q == WAIT_RESP) && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_valid) state_d = (decode_kind(in_kind) == NONE) ? OUT : REQ;
      REQ:       if (mem_req_ready) state_d = WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid || timeout_hit) state_d = OUT;
      OUT:       if (ex_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q          <= NONE;
      addr_q          <= '0;
      wdata_q         <= '0;
      memex           <= '0;
      load_buffer     <= '0;
      loadbuffer_done <= 1'b0;
      mem_err         <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        kind_q  <= decode_kind(in_kind);
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        memex   <= in_memex;
      end

      if (state_q == REQ && mem_req_ready)
        tmo_cnt <= '0;
      else if (state_q == WAIT_RESP && tmo_cnt != 8'hFF)
        tmo_cnt <= tmo_cnt + 8'd1;

      // A response on the timeout cycle still counts as a response.
      if (state_q == WAIT_RESP) begin
        if (mem_resp_valid) begin
          if (kind_q == LOAD) begin
            load_buffer     <= mem_resp_data;
            loadbuffer_done <= 1'b1;
          end
        end else if (timeout_hit) begin
          mem_err     <= 1'b1;
          load_buffer <= '0;
        end
      end

      if (state_q == OUT && ex_ready)
        loadbuffer_done <= 1'b0;
    end
  end

  assign in_ready              = (state_q == IDLE);
  assign mem_req_valid         = (state_q == REQ);
  assign mem_req_we            = (kind_q == STORE);
  assign mem_req_addr          = addr_q;
  assign mem_req_wdata         = wdata_q;
  assign can_execute           = (state_q == OUT);
  assign memstage_active       = (state_q != IDLE);
  assign store_memstage_active = (kind_q == STORE) &&
                                 (state_q == REQ || state_q == WAIT_RESP);

endmodule

// File: tb/tb_mod_memstage.sv
// Directed bench for mod_memstage: table of single transactions plus
// hand-written stall, backpressure, timeout and mid-transaction reset cases.
module tb_mod_memstage;
  import mod_memstage_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  MEM_EX       in_memex;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        ex_ready;
  logic        can_execute;
  MEM_EX       memex;
  logic [63:0] load_buffer;
  logic        loadbuffer_done;
  logic        memstage_active;
  logic        store_memstage_active;
  logic        mem_err;

  int n_pass  = 0;
  int n_total = 0;

  mod_memstage #(.DATA_W(64), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_memex(in_memex),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ex_ready(ex_ready), .can_execute(can_execute), .memex(memex),
    .load_buffer(load_buffer), .loadbuffer_done(loadbuffer_done),
    .memstage_active(memstage_active), .store_memstage_active(store_memstage_active),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  opcode;
    logic [63:0] rdata;
    int          lat;
    logic        exp_req;
    logic        exp_we;
    logic        exp_done;
    logic [63:0] exp_lb;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic MEM_EX mk_memex(input logic [7:0] op, input logic [63:0] operand);
    MEM_EX m;
    m = '0;
    m.ctl_opcode = op;
    m.rd         = op[4:0];
    m.wb_en      = 1'b1;
    m.operand    = operand;
    return m;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_kind = 2'b00; in_addr = '0; in_wdata = '0; in_memex = '0;
  endtask

  task automatic accept(input logic [1:0] kind, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] op);
    in_valid = 1'b1; in_kind = kind; in_addr = addr; in_wdata = wdata;
    in_memex = mk_memex(op, addr ^ 64'h5555);
    tick();
    idle_inputs();
  endtask

  task automatic drain();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    chk("vec_in_ready", 64'(in_ready), 64'd1);
    accept(v.kind, v.addr, v.wdata, v.opcode);
    cyc = 1;
    chk("vec_req_valid", 64'(mem_req_valid), 64'(v.exp_req));
    if (v.exp_req) begin
      chk("vec_req_we", 64'(mem_req_we), 64'(v.exp_we));
      chk("vec_req_addr", mem_req_addr, v.addr);
      if (v.exp_we) chk("vec_req_wdata", mem_req_wdata, v.wdata);
      mem_req_ready = 1'b1;
      tick(); cyc++;
      mem_req_ready = 1'b0;
      for (int k = 1; k < v.lat; k++) begin
        tick(); cyc++;
      end
      chk("vec_no_exec_before_resp", 64'(can_execute), 64'd0);
      mem_resp_valid = 1'b1; mem_resp_data = v.rdata;
      tick(); cyc++;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
    end
    chk("vec_latency", 64'(cyc), v.exp_req ? 64'(2 + v.lat) : 64'd1);
    chk("vec_can_execute", 64'(can_execute), 64'd1);
    chk("vec_opcode", 64'(memex.ctl_opcode), 64'(v.opcode));
    chk("vec_operand", memex.operand, v.addr ^ 64'h5555);
    chk("vec_lb_done", 64'(loadbuffer_done), 64'(v.exp_done));
    if (v.exp_done) chk("vec_load_buffer", load_buffer, v.exp_lb);
    drain();
    chk("vec_back_idle", 64'(in_ready), 64'd1);
    chk("vec_lb_done_clr", 64'(loadbuffer_done), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{2'b00, 64'h0, 64'h0, 8'hC7, 64'h0, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[1] = '{2'b01, 64'h1000, 64'h0, 8'h31, 64'h1122334455667788, 3, 1'b1, 1'b0, 1'b1, 64'h1122334455667788};
    vecs[2] = '{2'b11, 64'h44, 64'h99, 8'h5A, 64'h0, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[3] = '{2'b10, 64'h3008, 64'hCAFEF00D12345678, 8'h62, 64'hBAD0BAD0BAD0BAD0, 1, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[4] = '{2'b01, 64'hFFFFFFFFFFFFFFF8, 64'h0, 8'h13, 64'h8000000000000001, 1, 1'b1, 1'b0, 1'b1, 64'h8000000000000001};

    reset = 1'b1; idle_inputs();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; ex_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_can_execute", 64'(can_execute), 64'd0);
    chk("rst_active", 64'(memstage_active), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_load_buffer", load_buffer, 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Store held off by the memory for four cycles.
    accept(2'b10, 64'h2000, 64'hDEADBEEF, 8'h77);
    for (int k = 0; k < 4; k++) begin
      chk("st_req_valid", 64'(mem_req_valid), 64'd1);
      chk("st_req_addr", mem_req_addr, 64'h2000);
      chk("st_req_wdata", mem_req_wdata, 64'hDEADBEEF);
      chk("st_req_we", 64'(mem_req_we), 64'd1);
      chk("st_active", 64'(store_memstage_active), 64'd1);
      tick();
    end
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("st_wait_req_valid", 64'(mem_req_valid), 64'd0);
    chk("st_wait_active", 64'(store_memstage_active), 64'd1);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    chk("st_ack_active", 64'(store_memstage_active), 64'd0);
    chk("st_ack_exec", 64'(can_execute), 64'd1);
    chk("st_ack_lb_done", 64'(loadbuffer_done), 64'd0);
    drain();

    // Backpressure in OUT with a second instruction waiting upstream.
    accept(2'b00, 64'h10, 64'h0, 8'hA1);
    in_valid = 1'b1; in_kind = 2'b00; in_addr = 64'h20; in_memex = mk_memex(8'hB2, 64'h20);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_opcode_held", 64'(memex.ctl_opcode), 64'hA1);
      tick();
    end
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;
    chk("bp_idle_after_ready", 64'(in_ready), 64'd1);
    tick();
    idle_inputs();
    chk("bp_second_exec", 64'(can_execute), 64'd1);
    chk("bp_second_opcode", 64'(memex.ctl_opcode), 64'hB2);
    drain();

    // Load that never gets a response.
    accept(2'b01, 64'h5000, 64'h0, 8'h0E);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    n = 0;
    while (!can_execute && n < 400) begin
      tick(); n++;
    end
    chk("tmo_wait_cycles", 64'(n), 64'd255);
    chk("tmo_mem_err", 64'(mem_err), 64'd1);
    chk("tmo_can_execute", 64'(can_execute), 64'd1);
    chk("tmo_load_buffer", load_buffer, 64'd0);
    chk("tmo_lb_done", 64'(loadbuffer_done), 64'd0);
    drain();
    chk("tmo_err_sticky", 64'(mem_err), 64'd1);

    // Reset while waiting for a load response; the late response must be ignored.
    accept(2'b01, 64'h6000, 64'h0, 8'h2F);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    tick();
    chk("mr_in_wait", 64'(memstage_active), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 64'h0123456789ABCDEF;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk("mr_active", 64'(memstage_active), 64'd0);
    chk("mr_can_execute", 64'(can_execute), 64'd0);
    chk("mr_load_buffer", load_buffer, 64'd0);
    chk("mr_lb_done", 64'(loadbuffer_done), 64'd0);
    chk("mr_mem_err", 64'(mem_err), 64'd0);
    chk("mr_memex", 64'(memex.ctl_opcode), 64'd0);
    chk("mr_req_addr", mem_req_addr, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
